// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller.
//   rx_state_t     : controller state encoding (OFF / WAIT_FRAME / IN_FRAME)
//   timeout_cycles : converts a silence length in bit periods into clock cycles
package uart_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAIT = 2'd1,
        ST_IN   = 2'd2
    } rx_state_t;

    // Widened arithmetic so large clock rates times bit counts cannot overflow.
    function automatic int timeout_cycles(input int bits, input int clk_hz, input int bit_rate);
        return int'((longint'(bits) * longint'(clk_hz)) / longint'(bit_rate));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, reset      : clock, asynchronous active-high reset
//   push, push_data : write request; accepted when not full, or when full with a
//                     pop in the same cycle
//   pop             : read request; ignored while empty
//   head            : oldest entry, valid whenever not_empty=1
//   not_empty, full : status
//   count           : occupancy 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign not_empty = (count != '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign head      = mem[rd_ptr];

    // A pop frees the head slot at the same edge, so a full FIFO can still
    // take a write when it is also being read.
    assign do_pop  = pop && not_empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are AW bits wide: wrap modulo DEPTH is implicit.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: captures bytes from a receiver, buffers them in a
// FWFT FIFO and delimits frames by line silence.
//   clk, reset            : clock, asynchronous active-high reset
//   ctrl_enable           : enables reception; low aborts any open frame
//   clr_status            : clears overrun / break_seen (a set in the same cycle wins)
//   rx_valid, rx_data     : receiver byte; a byte is taken on the rising edge of rx_valid
//   rx_break              : receiver BREAK; blocks capture and sets break_seen
//   rx_en                 : registered enable back to the receiver
//   rd_en, rd_data        : FIFO pop / head byte
//   rd_valid, fifo_count  : FIFO not empty / occupancy
//   frame_done, frame_len : one-cycle frame-end pulse and length of the last frame
//   overrun, break_seen   : sticky status flags
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int BIT_RATE     = 9600,
    parameter int TIMEOUT_BITS = 20,
    parameter int FIFO_DEPTH   = 16,
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_enable,
    input  logic             clr_status,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_break,
    output logic             rx_en,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic [CNT_W-1:0] fifo_count,
    output logic             frame_done,
    output logic [7:0]       frame_len,
    output logic             overrun,
    output logic             break_seen
);

    localparam int TIMEOUT_CYC = timeout_cycles(TIMEOUT_BITS, CLK_HZ, BIT_RATE);
    localparam int IDLE_W      = $clog2(TIMEOUT_CYC + 1);

    rx_state_t   state, state_n;
    logic [IDLE_W-1:0] idle_cnt, idle_n;
    logic [7:0]  run_cnt, run_n, len_n;
    logic        done_n;
    logic        rx_valid_q;
    logic        capture, pop_ok, fifo_full;
    logic        overrun_set, break_set;

    // One capture per rx_valid high interval; BREAK and a disabled controller
    // swallow the edge.
    assign capture     = rx_valid && !rx_valid_q && !rx_break && ctrl_enable && (state != ST_OFF);
    assign pop_ok      = rd_en && rd_valid;
    assign overrun_set = capture && fifo_full && !pop_ok;
    assign break_set   = rx_break && (state != ST_OFF);

    always_comb begin
        state_n = state;
        idle_n  = idle_cnt;
        run_n   = run_cnt;
        len_n   = frame_len;
        done_n  = 1'b0;
        if (!ctrl_enable) begin
            // Abort: the open frame is dropped without touching frame_len.
            state_n = ST_OFF;
            idle_n  = '0;
            run_n   = '0;
        end else begin
            case (state)
                ST_OFF: state_n = ST_WAIT;
                ST_WAIT: begin
                    if (capture) begin
                        state_n = ST_IN;
                        idle_n  = '0;
                        run_n   = 8'd1;
                    end
                end
                ST_IN: begin
                    // A capture on the timeout cycle keeps the frame open.
                    if (capture) begin
                        idle_n = '0;
                        if (run_cnt != 8'hFF) run_n = run_cnt + 8'd1;
                    end else if (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
                        done_n  = 1'b1;
                        len_n   = run_cnt;
                        state_n = ST_WAIT;
                        idle_n  = '0;
                        run_n   = '0;
                    end else begin
                        idle_n = idle_cnt + IDLE_W'(1);
                    end
                end
                default: state_n = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_OFF;
            idle_cnt   <= '0;
            run_cnt    <= '0;
            frame_len  <= '0;
            frame_done <= 1'b0;
            rx_en      <= 1'b0;
            rx_valid_q <= 1'b0;
            overrun    <= 1'b0;
            break_seen <= 1'b0;
        end else begin
            state      <= state_n;
            idle_cnt   <= idle_n;
            run_cnt    <= run_n;
            frame_len  <= len_n;
            frame_done <= done_n;
            rx_en      <= (state != ST_OFF);
            rx_valid_q <= rx_valid;
            if (overrun_set)     overrun <= 1'b1;
            else if (clr_status) overrun <= 1'b0;
            if (break_set)       break_seen <= 1'b1;
            else if (clr_status) break_seen <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data (rx_data),
        .pop       (rd_en),
        .head      (rd_data),
        .not_empty (rd_valid),
        .full      (fifo_full),
        .count     (fifo_count)
    );

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL provide these parameters (name, default, meaning):
- CLK_HZ, 50000000, system clock frequency in Hz.
- BIT_RATE, 9600, UART bit rate.
- TIMEOUT_BITS, 20, bit periods of line silence that close a frame.
- FIFO_DEPTH, 16, byte buffer depth, power of two.
REQ-002 The block SHALL provide these ports (name, direction, width, meaning):
- clk, in, 1, single system clock.
- reset, in, 1, asynchronous, active-high reset.
- ctrl_enable, in, 1, enables reception.
- clr_status, in, 1, clears the sticky flags.
- rx_valid, in, 1, receiver data-valid; a level that may stay high for several cycles.
- rx_data, in, 8, receiver byte.
- rx_break, in, 1, receiver BREAK indication.
- rx_en, out, 1, enable to the receiver.
- rd_en, in, 1, pop request.
- rd_data, out, 8, FIFO head byte.
- rd_valid, out, 1, FIFO not empty.
- fifo_count, out, log2(FIFO_DEPTH)+1, occupancy.
- frame_done, out, 1, one-cycle frame-end pulse.
- frame_len, out, 8, byte count of the last closed frame.
- overrun, out, 1, sticky.
- break_seen, out, 1, sticky.

Function
REQ-003 The block SHALL compute TIMEOUT_CYC = TIMEOUT_BITS*CLK_HZ/BIT_RATE with integer division and size the idle counter to hold it.
REQ-004 The block SHALL capture a byte only on the rising edge of rx_valid, detected against a registered copy: exactly one capture per high interval.
REQ-005 The block SHALL implement the states OFF, WAIT_FRAME and IN_FRAME.
- OFF -> WAIT_FRAME when ctrl_enable=1.
- Any state -> OFF when ctrl_enable=0.
REQ-006 rx_en SHALL be a register that is 1 in WAIT_FRAME and IN_FRAME and 0 in OFF; it changes the cycle after the state changes.
REQ-007 In OFF, the block SHALL ignore captures; FIFO contents and frame_len are retained.
REQ-008 When ctrl_enable falls in IN_FRAME, the frame SHALL be aborted: no frame_done, frame_len unchanged.
REQ-009 In WAIT_FRAME, a capture SHALL move the state to IN_FRAME, clear the idle counter and set the running byte count to 1.
REQ-010 In IN_FRAME, a capture SHALL clear the idle counter and increment the running count, saturating at 255.
REQ-011 In IN_FRAME, the idle counter SHALL increment each cycle without a capture. When it reaches TIMEOUT_CYC-1, the block SHALL:
- pulse frame_done for one cycle,
- load frame_len with the running count,
- return to WAIT_FRAME.
REQ-012 A capture in the same cycle as the timeout SHALL take priority: the frame continues and no frame_done is issued.
REQ-013 The FIFO SHALL be first-word-fall-through:
- rd_data presents the head byte whenever rd_valid=1.
- rd_en with rd_valid=1 pops at the clock edge.
- rd_en with rd_valid=0 is ignored.
REQ-014 A capture with the FIFO full and no simultaneous pop SHALL drop the byte and set overrun. The dropped byte still counts toward the running frame count.
REQ-015 A capture and a pop in the same cycle SHALL both be performed, including when the FIFO is full; fifo_count is unchanged.
REQ-016 Read and write pointers SHALL wrap modulo FIFO_DEPTH. fifo_count SHALL range 0..FIFO_DEPTH.
REQ-017 rx_break=1 in any non-OFF state SHALL set break_seen. No byte is captured while rx_break=1.
REQ-018 clr_status=1 SHALL clear overrun and break_seen. A set condition in the same cycle SHALL win.

Reset
REQ-019 While reset=1, asynchronously, the block SHALL force:
- state=OFF, rx_en=0,
- FIFO empty (rd_valid=0, fifo_count=0, pointers 0),
- frame_done=0, frame_len=0,
- overrun=0, break_seen=0,
- idle counter, running count and rx_valid history register = 0.
REQ-020 Reset asserted mid-frame SHALL discard the frame and all buffered bytes. The first capture after release requires a fresh rx_valid rising edge.

Structure
REQ-021 The state encoding and the TIMEOUT_CYC computation function SHALL live in a shared package, uart_pkg.
REQ-022 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised by width and depth, with FWFT semantics and a simultaneous-push/pop-when-full capability.
REQ-023 The frame timer and the state machine SHALL reside in uart_rx_ctrl.

Verification
REQ-024 The bench SHALL cover these directed scenarios (CLK_HZ=1000, BIT_RATE=100, TIMEOUT_BITS=3 -> TIMEOUT_CYC=30):
- Enable, then 3 captures of 0x11, 0x22, 0x33 (rx_valid held 4 cycles each) -> fifo_count=3, no duplicates, frame_done 30 cycles after the last capture, frame_len=3.
- 17 captures with no reads at FIFO_DEPTH=16 -> fifo_count=16, overrun=1, 17th byte absent, head=first byte.
- Full FIFO, capture and rd_en in the same cycle -> fifo_count stays 16, new byte at the tail, no overrun.
- Capture exactly on the timeout cycle -> no frame_done, frame extends, frame_len counts all bytes.
- ctrl_enable dropped mid-frame -> rx_en=0 next cycle, no frame_done, FIFO retained.
- Assert reset mid-frame with 5 bytes buffered -> all outputs at reset values immediately, rd_valid=0.
